fod_half_div_gen: RTL and testbench

//  Programmable integer/half-integer clock divider. Generates the divided edge stream D and the per-period

---
 rtl/fod_half_div_gen.sv | 136 +++++++++++++
 tb/tb_fod_half_div_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fod_half_div_gen.sv
// Integer / half-integer clock divider: emits the divided edge stream and per-period retimer polarity.
// Optional build macro FOD_DUTY50_EN stretches the divided pulse to floor(L/2) cycles.
module fod_half_div_gen #(
    parameter int W       = 8,
    parameter int DIV_RST = 4
) (
    input  logic         ck_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] div_int_i,
    input  logic         div_half_i,
    input  logic         div_upd_i,
    output logic         div_ack_o,
    output logic         d_o,
    output logic         polarity_o
);

    // state | meaning
    // IDLE  | en low: outputs parked at 0, counter and half-phase cleared
    // RUN   | dividing; a period boundary occurs when cnt reaches L-1 or on entry
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t       state_q, state_d;
    logic [W:0]   cnt_q, cnt_d;
    logic [W:0]   len_q, len_d;
    logic [W-1:0] n_q, n_d;
    logic         half_q, half_d;
    logic [W-1:0] sh_n_q, sh_n_d;
    logic         sh_half_q, sh_half_d;
    logic         pend_q, pend_d;
    logic         p_cur_q, p_cur_d;
    logic         d_q, d_d;
    logic         pol_q, pol_d;
    logic         ack_q, ack_d;

    logic         boundary;
    logic [W-1:0] n_sel;
    logic         half_sel;
    logic         p_next;
    logic [W:0]   len_new;
    logic [W:0]   cnt_inc;

    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= (W+1)'(DIV_RST);
            n_q       <= W'(DIV_RST);
            half_q    <= 1'b0;
            sh_n_q    <= W'(DIV_RST);
            sh_half_q <= 1'b0;
            pend_q    <= 1'b0;
            p_cur_q   <= 1'b0;
            d_q       <= 1'b0;
            pol_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            n_q       <= n_d;
            half_q    <= half_d;
            sh_n_q    <= sh_n_d;
            sh_half_q <= sh_half_d;
            pend_q    <= pend_d;
            p_cur_q   <= p_cur_d;
            d_q       <= d_d;
            pol_q     <= pol_d;
            ack_q     <= ack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        n_d       = n_q;
        half_d    = half_q;
        sh_n_d    = sh_n_q;
        sh_half_d = sh_half_q;
        pend_d    = pend_q;
        p_cur_d   = p_cur_q;
        d_d       = 1'b0;
        pol_d     = pol_q;
        ack_d     = 1'b0;

        boundary = (state_q == S_IDLE) || (cnt_q == len_q - (W+1)'(1));
        n_sel    = pend_q ? sh_n_q : n_q;
        half_sel = pend_q ? sh_half_q : half_q;
        p_next   = half_sel & ~p_cur_q;
        // The long period is the one that closes a polarity-1 period.
        len_new  = {1'b0, n_sel} + (W+1)'(p_cur_q & ~p_next);
        cnt_inc  = cnt_q + (W+1)'(1);

        if (en_i) begin
            state_d = S_RUN;
            if (boundary) begin
                cnt_d   = '0;
                len_d   = len_new;
                pol_d   = p_next;
                p_cur_d = p_next;
                d_d     = 1'b1;
                if (pend_q) begin
                    n_d    = sh_n_q;
                    half_d = sh_half_q;
                    pend_d = 1'b0;
                    ack_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_inc;
`ifdef FOD_DUTY50_EN
                d_d = (cnt_inc < (len_q >> 1));
`else
                d_d = 1'b0;
`endif
            end
        end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            p_cur_d = 1'b0;
            pol_d   = 1'b0;
        end

        // A strobe on the boundary cycle lands in the shadow after the load above.
        if (div_upd_i) begin
            sh_n_d    = (div_int_i < W'(2)) ? W'(2) : div_int_i;
            sh_half_d = div_half_i;
            pend_d    = 1'b1;
        end
    end

    assign div_ack_o  = ack_q;
    assign d_o        = d_q;
    assign polarity_o = pol_q;

endmodule

// File: tb/tb_fod_half_div_gen.sv
// Scoreboard bench for fod_half_div_gen: a period-level reference model queues per-cycle expectations,
// a negedge monitor pops and compares. Honours FOD_DUTY50_EN when defined.
module tb_fod_half_div_gen;
    localparam int W = 8;
    localparam int DIV_RST = 4;

    logic         ck = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] dint = '0;
    logic         dhalf = 1'b0;
    logic         upd = 1'b0;
    logic         ack, d, pol;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct packed {
        logic d;
        logic pol;
        logic ack;
    } exp_t;
    exp_t exp_q[$];

    // reference model state (period level)
    int m_run, m_pos, m_len, m_pcur, m_n, m_half, m_sn, m_sh, m_pend;
    int m_acks;

    fod_half_div_gen #(.W(W), .DIV_RST(DIV_RST)) dut (
        .ck_i(ck), .rst_i(rst), .en_i(en), .div_int_i(dint), .div_half_i(dhalf),
        .div_upd_i(upd), .div_ack_o(ack), .d_o(d), .polarity_o(pol)
    );

    always #5 ck = ~ck;

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_len = DIV_RST; m_pcur = 0;
        m_n = DIV_RST; m_half = 0; m_sn = DIV_RST; m_sh = 0; m_pend = 0;
    endtask

    // Advance the model by one CK edge with the inputs sampled at that edge.
    task automatic model_step(input logic r, input logic e, input logic u,
                              input int di, input logic dh);
        exp_t x;
        int pnext;
        x = '0;
        if (r) begin
            model_reset();
        end else begin
            if (!e) begin
                m_run = 0; m_pos = 0; m_pcur = 0;
            end else if (!m_run || m_pos == m_len - 1) begin
                if (m_pend) begin
                    m_n = m_sn; m_half = m_sh; m_pend = 0;
                    x.ack = 1'b1; m_acks++;
                end
                pnext = m_half ? 1 - m_pcur : 0;
                m_len = m_n + ((m_pcur == 1 && pnext == 0) ? 1 : 0);
                m_pcur = pnext;
                m_pos = 0;
                m_run = 1;
            end else begin
                m_pos++;
            end
            if (m_run) begin
                x.pol = m_pcur[0];
`ifdef FOD_DUTY50_EN
                x.d = (m_pos < m_len / 2);
`else
                x.d = (m_pos == 0);
`endif
            end
            if (u) begin
                m_sn = (di < 2) ? 2 : di;
                m_sh = dh;
                m_pend = 1;
            end
        end
        exp_q.push_back(x);
    endtask

    task automatic cyc_drv(input logic r, input logic e, input logic u,
                           input int di, input logic dh);
        rst = r; en = e; upd = u; dint = W'(di); dhalf = dh;
        @(posedge ck);
        model_step(r, e, u, di, dh);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc_drv(1'b0, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic strobe(input int di, input logic dh);
        cyc_drv(1'b0, 1'b1, 1'b1, di, dh);
    endtask

    // Monitor: compares DUT outputs once per cycle against the oldest queued expectation.
    always @(negedge ck) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_checks += 3;
            if (d !== x.d) begin
                n_fail++;
                $display("FAIL d cyc=%0d got=%b exp=%b", cyc, d, x.d);
            end
            if (pol !== x.pol) begin
                n_fail++;
                $display("FAIL polarity cyc=%0d got=%b exp=%b", cyc, pol, x.pol);
            end
            if (ack !== x.ack) begin
                n_fail++;
                $display("FAIL div_ack cyc=%0d got=%b exp=%b", cyc, ack, x.ack);
            end
        end
    end

    initial begin
        int acks_before;
        model_reset();
        m_acks = 0;
        // 1: reset then default ratio 4
        cyc_drv(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cyc_drv(1'b1, 1'b1, 1'b1, 9, 1'b1);
        run(20);
        n_checks++;
        if (m_acks != 0 || m_n != DIV_RST) begin
            n_fail++;
            $display("FAIL reset_ratio acks=%0d n=%0d exp acks=0 n=%0d", m_acks, m_n, DIV_RST);
        end
        // 2: N=4.5
        strobe(4, 1'b1);
        run(30);
        // 3: clamp
        strobe(0, 1'b0);
        run(12);
        strobe(1, 1'b0);
        run(8);
        strobe(1, 1'b1);
        run(15);
        // 4: two strobes, second on the boundary cycle
        strobe(5, 1'b0);
        while (!(m_run && m_pos == m_len - 1)) run(1);
        acks_before = m_acks;
        strobe(7, 1'b0);
        run(20);
        n_checks++;
        if (m_acks - acks_before != 2 || m_n != 7) begin
            n_fail++;
            $display("FAIL double_strobe acks=%0d n=%0d exp acks=2 n=7", m_acks - acks_before, m_n);
        end
        // 5: en low mid-period, rst mid-run, restart in half mode
        strobe(4, 1'b1);
        run(10);
        cyc_drv(1'b0, 1'b0, 1'b0, 0, 1'b0);
        cyc_drv(1'b0, 1'b0, 1'b1, 3, 1'b1);
        run(12);
        run(3);
        cyc_drv(1'b1, 1'b1, 1'b0, 0, 1'b0);
        strobe(3, 1'b1);
        run(14);
        // exit from half mode while long period pending
        strobe(6, 1'b0);
        run(25);
        // widest ratio: L = 256 must not wrap
        strobe(255, 1'b1);
        run(800);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic r, e, u, h;
            int di;
            r  = ($urandom_range(0, 299) == 0);
            e  = ($urandom_range(0, 39) != 0);
            u  = ($urandom_range(0, 7) == 0);
            h  = $urandom_range(0, 1) == 1;
            di = ($urandom_range(0, 49) == 0) ? 255 : $urandom_range(0, 9);
            cyc_drv(r, e, u, di, h);
        end
        @(negedge ck);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
